// File: rtl/sb_tx_arbiter_if.sv
// Request/issue bundle between the two substate FSMs, the sideband and sb_tx_arbiter.
// The arbiter connects through the slave modport; the requester/sideband side uses master.
interface sb_tx_arbiter_if #(
  parameter int SB_MSG_WIDTH = 4
);
  logic                    i_en;
  logic                    i_tx_req;
  logic                    i_rx_req;
  logic [SB_MSG_WIDTH-1:0] i_tx_msg;
  logic [SB_MSG_WIDTH-1:0] i_rx_msg;
  logic [2:0]              i_tx_info;
  logic [2:0]              i_rx_info;
  logic                    i_SB_Busy;

  logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg;
  logic                    o_tx_msg_valid;
  logic [2:0]              o_tx_msg_info;
  logic                    o_tx_grant;
  logic                    o_rx_grant;
  logic                    o_tx_done;
  logic                    o_rx_done;
  logic                    o_timeout;

  modport master (
    output i_en, i_tx_req, i_rx_req, i_tx_msg, i_rx_msg, i_tx_info, i_rx_info, i_SB_Busy,
    input  o_encoded_SB_msg, o_tx_msg_valid, o_tx_msg_info,
           o_tx_grant, o_rx_grant, o_tx_done, o_rx_done, o_timeout
  );

  modport slave (
    input  i_en, i_tx_req, i_rx_req, i_tx_msg, i_rx_msg, i_tx_info, i_rx_info, i_SB_Busy,
    output o_encoded_SB_msg, o_tx_msg_valid, o_tx_msg_info,
           o_tx_grant, o_rx_grant, o_tx_done, o_rx_done, o_timeout
  );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Sideband transmit arbiter: round-robin between the TX- and RX-side substate FSMs,
// issues one message to the sideband and tracks the busy rise/fall that completes it.
module sb_tx_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  sb_tx_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  localparam logic OWN_TX = 1'b0;
  localparam logic OWN_RX = 1'b1;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic [2:0]              info_q, info_d;
  logic                    valid_q, valid_d;
  logic                    tx_grant_q, tx_grant_d;
  logic                    rx_grant_q, rx_grant_d;
  logic                    tx_done_q, tx_done_d;
  logic                    rx_done_q, rx_done_d;
  logic                    timeout_q, timeout_d;

  logic any_req;
  logic pick_rx;

  assign any_req = bus.i_tx_req | bus.i_rx_req;
  // On a tie the requester that was not served last wins.
  assign pick_rx = bus.i_rx_req & (~bus.i_tx_req | (last_q == OWN_TX));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    msg_d      = msg_q;
    info_d     = info_q;
    valid_d    = 1'b0;
    tx_grant_d = 1'b0;
    rx_grant_d = 1'b0;
    tx_done_d  = 1'b0;
    rx_done_d  = 1'b0;
    timeout_d  = 1'b0;

    if (!bus.i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      msg_d   = '0;
      info_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          msg_d  = '0;
          info_d = '0;
          if (!bus.i_SB_Busy && any_req) begin
            owner_d    = pick_rx ? OWN_RX : OWN_TX;
            msg_d      = pick_rx ? bus.i_rx_msg  : bus.i_tx_msg;
            info_d     = pick_rx ? bus.i_rx_info : bus.i_tx_info;
            tx_grant_d = ~pick_rx;
            rx_grant_d = pick_rx;
            valid_d    = 1'b1;
            state_d    = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = ST_WAIT_HIGH;
        end

        ST_WAIT_HIGH: begin
          if (bus.i_SB_Busy) begin
            state_d = ST_WAIT_LOW;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            msg_d     = '0;
            info_d    = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_WAIT_LOW: begin
          if (!bus.i_SB_Busy) begin
            tx_done_d = (owner_q == OWN_TX);
            rx_done_d = (owner_q == OWN_RX);
            last_d    = owner_q;
            state_d   = ST_IDLE;
            msg_d     = '0;
            info_d    = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          msg_d   = '0;
          info_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_TX;
      last_q     <= OWN_TX;
      msg_q      <= '0;
      info_q     <= '0;
      valid_q    <= 1'b0;
      tx_grant_q <= 1'b0;
      rx_grant_q <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      msg_q      <= msg_d;
      info_q     <= info_d;
      valid_q    <= valid_d;
      tx_grant_q <= tx_grant_d;
      rx_grant_q <= rx_grant_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_encoded_SB_msg = msg_q;
  assign bus.o_tx_msg_info    = info_q;
  assign bus.o_tx_msg_valid   = valid_q;
  assign bus.o_tx_grant       = tx_grant_q;
  assign bus.o_rx_grant       = rx_grant_q;
  assign bus.o_tx_done        = tx_done_q;
  assign bus.o_rx_done        = rx_done_q;
  assign bus.o_timeout        = timeout_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Scoreboard bench for sb_tx_arbiter: the stimulus side predicts each issue/done/timeout/abort
// event from the arbitration rules; a monitor pops and compares as the outputs appear.
module tb_sb_tx_arbiter;
  localparam int W  = 4;
  localparam int TO = 16;

  typedef enum int {EV_ISSUE, EV_DONE, EV_TIMEOUT, EV_ABORT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    bit          rx;
    logic [W-1:0] msg;
    logic [2:0]  info;
    int unsigned cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sb_tx_arbiter_if #(.SB_MSG_WIDTH(W)) ifc ();

  sb_tx_arbiter #(.SB_MSG_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  bit  last_rx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({ifc.o_encoded_SB_msg, ifc.o_tx_msg_info, ifc.o_tx_msg_valid, ifc.o_tx_grant,
                ifc.o_rx_grant, ifc.o_tx_done, ifc.o_rx_done, ifc.o_timeout});
  endfunction

  // Monitor
  initial begin : monitor
    bit           active;
    logic [W-1:0] amsg;
    logic [2:0]   ainfo;
    ev_t          e;
    active = 1'b0;
    amsg   = '0;
    ainfo  = '0;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: kind %0d due at cycle %0d, now cycle %0d", int'(e.kind), e.cyc, cyc);
        if (e.kind != EV_ISSUE) active = 1'b0;
      end
      chk("pulse_exclusive", 32'($countones({ifc.o_tx_grant, ifc.o_rx_grant, ifc.o_tx_done,
                                              ifc.o_rx_done, ifc.o_timeout}) <= 1), 32'd1);
      chk("grant_with_valid", 32'(ifc.o_tx_grant | ifc.o_rx_grant), 32'(ifc.o_tx_msg_valid));
      if (ifc.o_tx_msg_valid || ifc.o_tx_done || ifc.o_rx_done || ifc.o_timeout) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: outputs %0h with no event expected (cycle %0d)", all_outputs(), cyc);
        end else begin
          e = expq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          case (e.kind)
            EV_ISSUE: begin
              chk("issue_valid", 32'(ifc.o_tx_msg_valid), 32'd1);
              chk("tx_grant", 32'(ifc.o_tx_grant), 32'(!e.rx));
              chk("rx_grant", 32'(ifc.o_rx_grant), 32'(e.rx));
              chk("issue_msg", 32'(ifc.o_encoded_SB_msg), 32'(e.msg));
              chk("issue_info", 32'(ifc.o_tx_msg_info), 32'(e.info));
              active = 1'b1;
              amsg   = e.msg;
              ainfo  = e.info;
            end
            EV_DONE: begin
              chk("tx_done", 32'(ifc.o_tx_done), 32'(!e.rx));
              chk("rx_done", 32'(ifc.o_rx_done), 32'(e.rx));
              active = 1'b0;
            end
            EV_TIMEOUT: begin
              chk("timeout", 32'(ifc.o_timeout), 32'd1);
              active = 1'b0;
            end
            default: begin
              chk("abort_no_pulse", all_outputs(), 32'd0);
              active = 1'b0;
            end
          endcase
        end
      end else if (expq.size() > 0 && expq[0].kind == EV_ABORT && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("abort_outputs", all_outputs(), 32'd0);
        active = 1'b0;
      end
      if (!ifc.o_tx_msg_valid) begin
        chk("msg_hold", 32'(ifc.o_encoded_SB_msg), active ? 32'(amsg) : 32'd0);
        chk("info_hold", 32'(ifc.o_tx_msg_info), active ? 32'(ainfo) : 32'd0);
      end
    end
  end

  // One request/issue/busy sequence; abort_mode 1 drops i_en in WAIT_BUSY_LOW, 2 pulses reset in ISSUE.
  task automatic do_xfer(input bit add_tx, input bit add_rx,
                         input logic [W-1:0] tm, input logic [2:0] ti,
                         input logic [W-1:0] rm, input logic [2:0] ri,
                         input int rise, input int len, input int pre_busy,
                         input bit keep_loser, input int abort_mode, output bit held);
    bit          win_rx;
    int          n;
    int unsigned vcyc;
    ev_t         e;
    held = 1'b0;
    if (add_tx && !ifc.i_tx_req) begin
      ifc.i_tx_msg = tm; ifc.i_tx_info = ti; ifc.i_tx_req = 1'b1;
    end
    if (add_rx && !ifc.i_rx_req) begin
      ifc.i_rx_msg = rm; ifc.i_rx_info = ri; ifc.i_rx_req = 1'b1;
    end
    win_rx = ifc.i_rx_req && (!ifc.i_tx_req || !last_rx);
    e.kind = EV_ISSUE;
    e.rx   = win_rx;
    e.msg  = win_rx ? ifc.i_rx_msg  : ifc.i_tx_msg;
    e.info = win_rx ? ifc.i_rx_info : ifc.i_tx_info;
    if (pre_busy > 0) begin
      ifc.i_SB_Busy = 1'b1;
      repeat (pre_busy) @(negedge clk);
      ifc.i_SB_Busy = 1'b0;
    end
    e.cyc = cyc + 1;
    expq.push_back(e);

    n = 0;
    while (!ifc.o_tx_msg_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ifc.o_tx_msg_valid) begin
      errors++;
      $display("FAIL issue_wait: o_tx_msg_valid 0 after 10 cycles, required 1");
      ifc.i_tx_req = 1'b0;
      ifc.i_rx_req = 1'b0;
      return;
    end
    vcyc = cyc;

    // Winner withdraws and scribbles its message; the latched transfer must not change.
    if (win_rx) begin
      ifc.i_rx_req = 1'b0; ifc.i_rx_msg = W'($urandom); ifc.i_rx_info = 3'($urandom);
    end else begin
      ifc.i_tx_req = 1'b0; ifc.i_tx_msg = W'($urandom); ifc.i_tx_info = 3'($urandom);
    end
    if (!keep_loser || abort_mode != 0) begin
      ifc.i_tx_req = 1'b0;
      ifc.i_rx_req = 1'b0;
    end
    held = win_rx ? ifc.i_tx_req : ifc.i_rx_req;

    if (abort_mode == 2) begin
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", all_outputs(), 32'd0);
      e.kind = EV_ABORT; e.cyc = cyc + 1;
      expq.push_back(e);
      last_rx = 1'b0;
      held    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    if (rise < 0) begin
      e.kind = EV_TIMEOUT; e.cyc = vcyc + TO + 1;
      expq.push_back(e);
      repeat (TO + 1) @(negedge clk);
      return;
    end

    repeat (rise) @(negedge clk);
    ifc.i_SB_Busy = 1'b1;
    repeat (len) @(negedge clk);

    if (abort_mode == 1) begin
      ifc.i_en = 1'b0;
      e.kind = EV_ABORT; e.cyc = cyc + 1;
      expq.push_back(e);
      @(negedge clk);
      ifc.i_SB_Busy = 1'b0;
      @(negedge clk);
      ifc.i_en = 1'b1;
      return;
    end

    ifc.i_SB_Busy = 1'b0;
    e.kind = EV_DONE; e.cyc = cyc + 1;
    expq.push_back(e);
    last_rx = win_rx;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish by 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit held;
    int r;
    int rise;
    bit keep;
    rst = 1'b1;
    ifc.i_en = 1'b1;
    ifc.i_tx_req = 1'b0;  ifc.i_rx_req = 1'b0;
    ifc.i_tx_msg = '0;    ifc.i_rx_msg = '0;
    ifc.i_tx_info = '0;   ifc.i_rx_info = '0;
    ifc.i_SB_Busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single TX request, busy rises 2 cycles after valid and falls 3 later
    do_xfer(1'b1, 1'b0, 4'h5, 3'h2, 4'h0, 3'h0, 2, 3, 0, 1'b0, 0, held);
    repeat (2) @(negedge clk);

    // Tie from reset: RX first, held TX next, then RX again on the following tie
    do_xfer(1'b1, 1'b1, 4'h3, 3'h1, 4'h9, 3'h6, 1, 2, 0, 1'b1, 0, held);
    do_xfer(1'b0, 1'b0, 4'h0, 3'h0, 4'h0, 3'h0, 0, 3, 0, 1'b0, 0, held);
    @(negedge clk);
    do_xfer(1'b1, 1'b1, 4'h3, 3'h1, 4'h9, 3'h6, 2, 2, 0, 1'b0, 0, held);
    @(negedge clk);

    // Busy never rises: timeout, pointer untouched so TX wins the next tie twice
    do_xfer(1'b1, 1'b1, 4'hA, 3'h3, 4'hB, 3'h4, -1, 0, 0, 1'b0, 0, held);
    do_xfer(1'b1, 1'b1, 4'hC, 3'h5, 4'hD, 3'h7, 1, 2, 0, 1'b0, 0, held);

    // Busy already high while requesting: no grant until it drops
    do_xfer(1'b0, 1'b1, 4'h0, 3'h0, 4'h7, 3'h2, 1, 2, 5, 1'b0, 0, held);
    @(negedge clk);

    // i_en dropped in WAIT_BUSY_LOW, then reset pulsed during ISSUE
    do_xfer(1'b1, 1'b1, 4'hE, 3'h1, 4'h1, 3'h5, 1, 2, 0, 1'b0, 1, held);
    do_xfer(1'b1, 1'b1, 4'h6, 3'h3, 4'h8, 3'h4, 1, 2, 0, 1'b0, 2, held);
    @(negedge clk);
    do_xfer(1'b1, 1'b1, 4'h2, 3'h0, 4'hF, 3'h7, 0, 2, 0, 1'b0, 0, held);

    held = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rise = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      keep = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (held) begin
        do_xfer(1'b0, 1'b0, '0, '0, '0, '0, rise, int'($urandom_range(2, 4)), 0, keep, 0, held);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r = int'($urandom_range(1, 3));
        do_xfer(r[0], r[1], W'($urandom), 3'($urandom), W'($urandom), 3'($urandom),
                rise, int'($urandom_range(2, 4)), ($urandom_range(0, 3) == 0) ? 3 : 0,
                keep, 0, held);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 Parameter SB_MSG_WIDTH, default 4, SHALL set the width of every encoded-message bus.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL set the busy-rise timeout in cycles; legal range 2..255.
REQ-003 i_clk  input  1  sole clock; all logic SHALL be clocked on its rising edge; one clock.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_en  input  1  arbiter enable from LTSM substate.
REQ-006 i_tx_req / i_rx_req  input  1 each  send request from the TX-side / RX-side substate FSM.
REQ-007 i_tx_msg / i_rx_msg  input  SB_MSG_WIDTH each  encoded SB message of each requester.
REQ-008 i_tx_info / i_rx_info  input  3 each  msg-info field of each requester.
REQ-009 i_SB_Busy  input  1  sideband busy; 1 = SB transmitting.
REQ-010 o_encoded_SB_msg  output  SB_MSG_WIDTH  message to SB.
REQ-011 o_tx_msg_valid  output  1  single-cycle issue strobe to SB.
REQ-012 o_tx_msg_info  output  3  msg-info to SB.
REQ-013 o_tx_grant / o_rx_grant  output  1 each  one-cycle accept pulse to the winner.
REQ-014 o_tx_done / o_rx_done  output  1 each  one-cycle completion pulse to the owner.
REQ-015 o_timeout  output  1  one-cycle pulse on busy-rise timeout.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_BUSY_HIGH, WAIT_BUSY_LOW; all outputs SHALL be registered.
REQ-017 IDLE: when i_en=1, i_SB_Busy=0 and at least one req=1, SHALL latch the winner's msg/info, set owner, pulse its grant next cycle, go ISSUE.
REQ-018 Single requester SHALL win; both requesting SHALL resolve round-robin via a 1-bit last-served pointer, favouring the requester not served last.
REQ-019 Pointer SHALL update only on a completed transfer (done pulse), never on timeout or abort.
REQ-020 IDLE with i_SB_Busy=1 SHALL not arbitrate; requests wait.
REQ-021 ISSUE: o_tx_msg_valid=1 for exactly one cycle (same cycle as grant), then go WAIT_BUSY_HIGH.
REQ-022 WAIT_BUSY_HIGH: i_SB_Busy=1 SHALL move to WAIT_BUSY_LOW; a 8-bit counter SHALL count cycles in this state.
REQ-023 Counter reaching TIMEOUT_CYC-1 without busy SHALL pulse o_timeout, give no done, return IDLE.
REQ-024 WAIT_BUSY_LOW: i_SB_Busy=0 (falling edge) SHALL pulse owner's done next cycle, update pointer, return IDLE.
REQ-025 Back-to-back: arbitration SHALL resume in the IDLE cycle following done; min issue-to-issue spacing 4 cycles.
REQ-026 o_encoded_SB_msg/o_tx_msg_info SHALL hold latched values in ISSUE..WAIT_BUSY_LOW and be 0 in IDLE.
REQ-027 Requests SHALL be level; requester holds req until grant; deassert before grant withdraws it; req during owner's transfer SHALL be ignored until IDLE.
REQ-028 Owner's req/msg changes after grant SHALL not affect the latched transfer.
REQ-029 i_en=0 in any state SHALL force IDLE at next edge, clear outputs, no done/timeout pulse, pointer kept.
REQ-030 Grant, done and timeout pulses SHALL be mutually exclusive per cycle; at most one grant per cycle.

Reset
REQ-031 i_rst=1 SHALL asynchronously force IDLE, counter 0, pointer = TX-served-last (RX wins first tie), all outputs 0.
REQ-032 Reset asserted mid-transfer SHALL drop the transfer with no done pulse; deassertion SHALL resume from IDLE.

Verification
REQ-033 Single TX req, msg=4'h5 info=3'h2, busy rises 2 cycles after valid and falls 3 later -> one valid pulse with 5/2, tx_grant with valid, tx_done 1 cycle after busy falls.
REQ-034 Both req from reset, msgs 4'h3/4'h9 -> RX (9) served first, then TX (3); the next tie RX again after TX completion.
REQ-035 Busy never rises, TIMEOUT_CYC=16 -> o_timeout exactly 16 cycles after entering WAIT_BUSY_HIGH, no done, pointer unchanged.
REQ-036 i_SB_Busy=1 while req asserted -> no grant until busy=0, then grant next cycle.
REQ-037 i_en dropped in WAIT_BUSY_LOW -> IDLE next cycle, outputs 0, no done; i_rst pulse mid-ISSUE -> all outputs 0 immediately.
